pc_sequencer: RTL
=================

# pc_sequencer

Instruction-fetch controller for the MUSA IF stage. Owns the program counter and sequences word-addressed fetches through a req/ack handshake to instruction memory. Delivers fetched instructions to ID through a stall-aware output register with a one-entry skid buffer, and applies branch, jump and exception redirects with fixed priority.

## Interface
- ADDR_W, 32, PC and memory address width (word addresses).
- DATA_W, 32, instruction width.
- RESET_VECTOR, 32'h0000_0000, PC after reset.
- EXC_VECTOR, 32'h0000_0010, PC on exception redirect.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- stall  in  1  ID cannot accept; if_* must hold.
- exc_req  in  1  exception redirect to EXC_VECTOR.
- br_taken  in  1  taken branch; target on br_target.
- br_target  in  ADDR_W  branch target.
- jmp  in  1  jump; target on jmp_target.
- jmp_target  in  ADDR_W  jump target.
- imem_req  out  1  fetch request.
- imem_addr  out  ADDR_W  fetch address; equals pc.
- imem_ack  in  1  data valid this cycle for the current request.
- imem_data  in  DATA_W  fetched word.
- if_valid  out  1  if_instr/if_pc hold a valid instruction.
- if_instr  out  DATA_W  instruction to ID.
- if_pc  out  ADDR_W  address of if_instr.

## Operation
- States: BOOT, FETCH, HOLD.
- BOOT is the reset state. imem_req=0. Next cycle go to FETCH.
- FETCH: imem_req=1, imem_addr=pc. Address is stable until ack, except on redirect.
- Ack in FETCH with no redirect and no discard: pc <= pc+1.
  - If the output register is empty or being consumed (stall=0), load it: if_valid=1, if_instr=imem_data, if_pc=pc.
  - Otherwise load the skid buffer and go to HOLD.
- HOLD: imem_req=0. When stall=0, ID consumes the output, skid moves to the output, skid is cleared, go to FETCH.
- Consumption means any cycle with if_valid=1 and stall=0. A consumed output with no new word gives if_valid=0.
- Redirect = exc_req | br_taken | jmp.
  - Target priority: exc_req (EXC_VECTOR) > br_taken > jmp.
  - On redirect: if_valid<=0, skid cleared, pc<=target, state<=FETCH. Redirect overrides stall.
  - If a request is outstanding and no ack arrives this cycle, set discard. imem_req drops for one cycle, and the next ack (belonging to the old request) is dropped without advancing pc.
  - If the ack arrives in the redirect cycle, drop the word and do not set discard.
- While discard=1, imem_req stays 0 until the ack. Then clear discard and resume fetching pc. A redirect during discard only updates pc.
- PC arithmetic is modulo 2^ADDR_W: 32'hFFFF_FFFF + 1 = 0, with no flag.

## Timing
- Reset values:
  - state=BOOT, pc=RESET_VECTOR
  - imem_req=0, imem_addr=RESET_VECTOR
  - if_valid=0, if_instr=0, if_pc=0
  - skid empty, discard=0
- Reset mid-request abandons it. imem must ignore stale acks after reset.
- First imem_req is 1 cycle after rst_n deasserts (BOOT lasts 1 cycle).
- Fetch latency: if_valid rises the cycle after imem_ack.
- With zero-wait memory (ack in the req cycle) and stall=0, throughput is 1 instruction/cycle and pc steps +1 each cycle.
- Redirect to first target request: the next cycle if nothing is outstanding. Otherwise the cycle after the discarded ack.
- stall has no effect on pc unless a word is accepted into the skid. At most one word is buffered beyond the output.

## Structure
- Package musa_if_pkg holds:
  - state enum (BOOT, FETCH, HOLD)
  - default RESET_VECTOR and EXC_VECTOR
  - ADDR_W and DATA_W defaults
- One sub-module: pc_incrementer, combinational pc+1, ADDR_W wide, wrap-around.
- Target-priority mux and FSM stay in pc_sequencer.

## Test plan
- Reset then zero-wait memory with stall=0 → imem_addr 0,1,2,3 on consecutive cycles; if_pc 0,1,2 with matching if_instr; first req 1 cycle after reset.
- Stall held 3 cycles while a request acks → output holds, skid filled, imem_req=0 in HOLD. On release, skid word appears the next cycle; no word is lost or duplicated.
- br_taken (target 0x40) with a 2-cycle-latency memory outstanding → old ack dropped, pc unchanged by it, next req addr=0x40, if_valid=0 until the 0x40 word arrives.
- exc_req, br_taken and jmp in the same cycle → next req addr=EXC_VECTOR (0x10).
- pc preset via jmp_target=32'hFFFF_FFFF → after that ack, next imem_addr=0.
- rst_n low for 1 cycle during an outstanding request → all outputs at reset values the next cycle; a late ack in BOOT is ignored.

Source files
------------

// File: rtl/musa_if_pkg.sv
// Shared types and default parameters for the MUSA instruction-fetch stage.
package musa_if_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;

    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR_DEF   = 32'h0000_0010;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory req/ack bus between the fetch sequencer (master) and imem (slave).
interface pc_sequencer_if #(
    parameter int unsigned ADDR_W = musa_if_pkg::ADDR_W_DEF,
    parameter int unsigned DATA_W = musa_if_pkg::DATA_W_DEF
) ();

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data
    );

endinterface

// File: rtl/pc_incrementer.sv
// Combinational next-sequential PC; wraps modulo 2^ADDR_W without any carry flag.
module pc_incrementer
    import musa_if_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0] pc_i,
    output logic [ADDR_W-1:0] pc_next_o
);

    assign pc_next_o = pc_i + ADDR_W'(1);

endmodule

// File: rtl/pc_sequencer.sv
// MUSA IF-stage fetch controller: owns the PC, sequences imem fetches and feeds ID
// through a stall-aware output register backed by a one-entry skid buffer.
module pc_sequencer
    import musa_if_pkg::*;
#(
    parameter int unsigned       ADDR_W       = ADDR_W_DEF,
    parameter int unsigned       DATA_W       = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(RESET_VECTOR_DEF),
    parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(EXC_VECTOR_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              exc_req,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              jmp,
    input  logic [ADDR_W-1:0] jmp_target,
    pc_sequencer_if.master    imem,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              req_q, req_d;
    logic              discard_q, discard_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_instr_q, out_instr_d;
    logic [ADDR_W-1:0] out_pc_q, out_pc_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_instr_q, skid_instr_d;
    logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;

    logic [ADDR_W-1:0] pc_inc;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_target;
    logic              ack_live;

    pc_incrementer #(.ADDR_W(ADDR_W)) u_pc_inc (
        .pc_i      (pc_q),
        .pc_next_o (pc_inc)
    );

    assign redirect        = exc_req | br_taken | jmp;
    assign redirect_target = exc_req  ? EXC_VECTOR :
                             br_taken ? br_target  : jmp_target;
    // An ack only belongs to us while our request is up; acks in BOOT/HOLD are stale.
    assign ack_live        = req_q & imem.imem_ack;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        discard_d    = discard_q;
        out_valid_d  = out_valid_q;
        out_instr_d  = out_instr_q;
        out_pc_d     = out_pc_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;

        if (redirect) begin
            // Any request still in flight (ours or an already-discarded one) poisons the next ack.
            pc_d         = redirect_target;
            state_d      = FETCH;
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
            discard_d    = (req_q | discard_q) & ~imem.imem_ack;
        end else begin
            if (out_valid_q && !stall) begin
                out_valid_d = 1'b0;
            end
            case (state_q)
                BOOT: state_d = FETCH;
                FETCH: begin
                    if (discard_q) begin
                        if (imem.imem_ack) begin
                            discard_d = 1'b0;
                        end
                    end else if (ack_live) begin
                        pc_d = pc_inc;
                        if (!out_valid_q || !stall) begin
                            out_valid_d = 1'b1;
                            out_instr_d = imem.imem_data;
                            out_pc_d    = pc_q;
                        end else begin
                            skid_valid_d = 1'b1;
                            skid_instr_d = imem.imem_data;
                            skid_pc_d    = pc_q;
                            state_d      = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        out_valid_d  = skid_valid_q;
                        out_instr_d  = skid_instr_q;
                        out_pc_d     = skid_pc_q;
                        skid_valid_d = 1'b0;
                        state_d      = FETCH;
                    end
                end
                default: state_d = BOOT;
            endcase
        end

        req_d = (state_d == FETCH) && !discard_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= BOOT;
            pc_q         <= RESET_VECTOR;
            req_q        <= 1'b0;
            discard_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_instr_q  <= '0;
            out_pc_q     <= '0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_q        <= req_d;
            discard_q    <= discard_d;
            out_valid_q  <= out_valid_d;
            out_instr_q  <= out_instr_d;
            out_pc_q     <= out_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;
    assign if_valid       = out_valid_q;
    assign if_instr       = out_instr_q;
    assign if_pc          = out_pc_q;

endmodule
